// File: rtl/mips_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module  : mips_writeback_regfile
// Brief   : Writeback pipeline register, 32x32 register file with bypassed
//           combinational rs/rt read ports, and a retired-result counter.
// Revision: 1.0 - initial release
// ============================================================================
module mips_writeback_regfile #(
    parameter int PRELOAD_EN = 1,
    parameter int XLEN       = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_data,
    input  logic [4:0]      rs_addr,
    input  logic [4:0]      rt_addr,
    output logic [XLEN-1:0] rs_data,
    output logic [XLEN-1:0] rt_data,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [31:0]     retire_count
);

    localparam logic [XLEN-1:0] C_R17_INIT = XLEN'(20);
    localparam logic [XLEN-1:0] C_R18_INIT = XLEN'(10);

    logic            wb_valid_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic [31:0]     retire_count_q;
    logic [31:0]     retire_count_d;
    logic [XLEN-1:0] regs_q [32];
    logic            commit_en_w;

    assign commit_en_w    = wb_valid_q && (wb_rd_q != 5'd0);
    assign retire_count_d = retire_count_q + {31'd0, wb_valid_q};

    // Writeback register: rd/data hold their value when no new result arrives.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= '0;
            retire_count_q <= 32'd0;
        end else begin
            wb_valid_q     <= in_valid;
            retire_count_q <= retire_count_d;
            if (in_valid) begin
                wb_rd_q   <= in_rd;
                wb_data_q <= in_data;
            end
        end
    end

    // Commit the pending result; a result pending at reset is discarded.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            if (PRELOAD_EN != 0) begin
                regs_q[17] <= C_R17_INIT;
                regs_q[18] <= C_R18_INIT;
            end
        end else if (commit_en_w) begin
            regs_q[wb_rd_q] <= wb_data_q;
        end
    end

    // Only the pending writeback is bypassed; in_* is deliberately not.
    always_comb begin
        rs_data = regs_q[rs_addr];
        if (rs_addr == 5'd0) begin
            rs_data = '0;
        end else if (wb_valid_q && (wb_rd_q == rs_addr)) begin
            rs_data = wb_data_q;
        end
    end

    always_comb begin
        rt_data = regs_q[rt_addr];
        if (rt_addr == 5'd0) begin
            rt_data = '0;
        end else if (wb_valid_q && (wb_rd_q == rt_addr)) begin
            rt_data = wb_data_q;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign retire_count = retire_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_writeback_regfile
// Brief   : Directed self-checking bench with a scoreboard of captured results.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips_writeback_regfile;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] retire_count;

    int checks = 0;
    int errors = 0;

    logic [36:0] sb_q[$];
    logic        exp_wb_valid = 1'b0;
    logic [31:0] exp_retire   = 32'd0;

    mips_writeback_regfile #(.PRELOAD_EN(1), .XLEN(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_rd        (in_rd),
        .in_data      (in_data),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .retire_count (retire_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock edge with optional capture; scoreboard checks the writeback register.
    task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] d);
        logic [36:0] e;
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
        if (v) sb_q.push_back({rd, d});
        @(posedge clock);
        #1;
        if (exp_wb_valid) exp_retire = exp_retire + 32'd1;
        exp_wb_valid = v;
        in_valid = 1'b0;
        check("wb_valid", {31'd0, wb_valid}, {31'd0, v});
        if (v) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("wb_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
                check("wb_data", wb_data, e[31:0]);
            end
        end
        check("retire_count", retire_count, exp_retire);
    endtask

    task automatic do_reset(input logic v);
        reset    = 1'b1;
        in_valid = v;
        in_rd    = 5'd8;
        in_data  = 32'd9;
        @(posedge clock);
        #1;
        reset        = 1'b0;
        in_valid     = 1'b0;
        exp_wb_valid = 1'b0;
        exp_retire   = 32'd0;
        sb_q.delete();
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_retire", retire_count, 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
        rs_addr = 5'd0; rt_addr = 5'd0;
        @(posedge clock);
        #1;
        do_reset(1'b1);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);

        rs_addr = 5'd17; rt_addr = 5'd18; #1;
        check("preload_r17", rs_data, 32'd20);
        check("preload_r18", rt_data, 32'd10);
        rs_addr = 5'd5; #1;
        check("reset_r5", rs_data, 32'd0);
        rs_addr = 5'd8; #1;
        check("reset_in_valid_ignored", rs_data, 32'd0);

        // Single result: no in_* bypass, then writeback bypass, then commit.
        rs_addr = 5'd19; rt_addr = 5'd19;
        in_valid = 1'b1; in_rd = 5'd19; in_data = 32'd30; #1;
        check("no_in_bypass", rs_data, 32'd0);
        step(1'b1, 5'd19, 32'd30);
        check("bypass_r19", rs_data, 32'd30);
        step(1'b0, 5'd0, 32'd0);
        check("commit_r19_rs", rs_data, 32'd30);
        check("commit_r19_rt", rt_data, 32'd30);

        // Back-to-back to the same register.
        step(1'b1, 5'd19, 32'd30); check("b2b_0", rs_data, 32'd30);
        step(1'b1, 5'd19, 32'd10); check("b2b_1", rs_data, 32'd10);
        step(1'b1, 5'd19, 32'd0);  check("b2b_2", rs_data, 32'd0);
        step(1'b1, 5'd19, 32'd30); check("b2b_3", rs_data, 32'd30);
        step(1'b0, 5'd0, 32'd0);
        check("b2b_final", rs_data, 32'd30);
        check("b2b_retire", retire_count, 32'd5);

        // Back-to-back to different registers, both read ports.
        step(1'b1, 5'd3, 32'h1111_2222);
        step(1'b1, 5'd4, 32'h3333_4444);
        rs_addr = 5'd3; rt_addr = 5'd4; #1;
        check("diff_rs3", rs_data, 32'h1111_2222);
        check("diff_rt4", rt_data, 32'h3333_4444);
        step(1'b0, 5'd0, 32'd0);
        check("diff_rt4_commit", rt_data, 32'h3333_4444);

        // Writes to R0 are dropped but still retire.
        rs_addr = 5'd0; rt_addr = 5'd0;
        step(1'b1, 5'd0, 32'hDEAD_BEEF);
        check("r0_bypass_rs", rs_data, 32'd0);
        step(1'b0, 5'd0, 32'd0);
        check("r0_commit_rt", rt_data, 32'd0);
        check("hold_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("hold_wb_data", wb_data, 32'hDEAD_BEEF);

        // Pending writeback discarded by reset asserted with in_valid.
        step(1'b1, 5'd7, 32'd5);
        do_reset(1'b1);
        rs_addr = 5'd7; rt_addr = 5'd8; #1;
        check("rst_drop_r7", rs_data, 32'd0);
        check("rst_drop_r8", rt_data, 32'd0);
        rs_addr = 5'd17; rt_addr = 5'd19; #1;
        check("rst_r17", rs_data, 32'd20);
        check("rst_r19", rt_data, 32'd0);

        // retire_count wrap.
        force dut.retire_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_q;
        exp_retire = 32'hFFFF_FFFF;
        rs_addr = 5'd4;
        step(1'b1, 5'd4, 32'd1);
        step(1'b0, 5'd0, 32'd0);
        check("wrap_zero", retire_count, 32'd0);
        check("wrap_commit_r4", rs_data, 32'd1);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_writeback_regfile.md
Name: mips_writeback_regfile

Overview:
- Writeback stage plus architectural register file for the MIPS R-type datapath.
- Sits directly downstream of the execute/ALU stage and consumes its result (ALUOut) and destination register (IR[15:11]).
- Holds one writeback pipeline register and commits it to the 32x32 register file.
- Supplies the rs/rt operands read by execute, with bypass from the pending writeback.

Parameters:
- PRELOAD_EN, 1, when 1, reset loads R17=20 and R18=10; all other registers reset to 0. When 0, all registers reset to 0.
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clock  input  1  single system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clock.
- in_valid  input  1  execute stage presents a result this cycle.
- in_rd  input  5  destination register index (IR[15:11]).
- in_data  input  32  ALU result.
- rs_addr  input  5  read port A index (IR[25:21]).
- rt_addr  input  5  read port B index (IR[20:16]).
- rs_data  output  32  combinational read port A with bypass.
- rt_data  output  32  combinational read port B with bypass.
- wb_valid  output  1  registered; writeback register holds a result.
- wb_rd  output  5  registered destination index.
- wb_data  output  32  registered result.
- retire_count  output  32  registered count of committed results.

Behaviour:
- Reset (reset=1 at posedge):
  - wb_valid=0, wb_rd=0, wb_data=0, retire_count=0.
  - Register file cleared; R17=20 and R18=10 if PRELOAD_EN=1.
  - Reset overrides every other input, including in_valid in the same cycle.
  - A writeback pending at reset is discarded and not committed.
- Capture: at posedge N with in_valid=1, the writeback register loads wb_valid=1, wb_rd=in_rd, wb_data=in_data, visible after edge N.
  - With in_valid=0, wb_valid goes 0; wb_rd and wb_data hold their previous values.
- Commit: at posedge N+1, if wb_valid=1 and wb_rd!=0, RegFile[wb_rd] is written with wb_data.
  - Latency from in_valid to architectural state is 2 edges.
- Simultaneous capture and commit: a new capture and the commit of the previous result happen on the same edge. Back-to-back results, one per cycle, are sustained with no stall.
- retire_count increments by 1 on every edge where wb_valid=1, including wb_rd=0. It wraps 0xFFFFFFFF -> 0.
- Read ports (combinational, identical logic for rs and rt):
  - addr==0 -> 0, always.
  - Otherwise, if wb_valid=1 and wb_rd==addr -> wb_data (bypass).
  - Otherwise -> RegFile[addr].
  - The in_* inputs are NOT bypassed: a read in the same cycle as in_valid returns the older value.
- Register 0:
  - Writes to R0 are dropped and R0 reads 0 always.
  - wb_valid and wb_data still reflect the captured value, and the result still counts as retired.
- Same rd on consecutive cycles: the later result wins in both the register file and the bypass; the earlier result commits first.
- Widths: all data 32-bit, no sign or zero extension, no overflow detection.

Test Plan:
- Reset with PRELOAD_EN=1 -> rs_addr=17 reads 20, rt_addr=18 reads 10, rs_addr=5 reads 0, wb_valid=0, retire_count=0.
- in_valid=1, rd=19, data=30 at edge 1 -> after edge 1: wb_valid=1, rs_addr=19 reads 30 via bypass. After edge 2 with in_valid=0: RegFile[19]=30, wb_valid=0, rs_addr=19 still reads 30, retire_count=1.
- Back-to-back rd=19 with data 30, 10, 0, 30 on four consecutive edges -> after each edge, rs_data(19) shows the latest value. After edge 5, RegFile[19]=30 and retire_count=4.
- in_valid=1, rd=0, data=0xDEADBEEF -> wb_valid=1, wb_data=0xDEADBEEF, rs_addr=0 reads 0 on all cycles, RegFile[0] unchanged, retire_count increments.
- in_valid=1, rd=7, data=5, then reset=1 on the next edge -> RegFile[7]=0, wb_valid=0, retire_count=0. A reset asserted together with in_valid=1 captures nothing.
- Force retire_count to 0xFFFFFFFF (or run 2^32 results in a fast model), then one commit -> retire_count=0.
